dmem_arbiter: RTL and testbench

- Shares the single-port byte-addressed data RAM between two requesters: port 0 (core load/store unit) and port 1 (loader/debug DMA).
- Per-port valid/ready request handshake with round-robin grant, at most one RAM access per cycle.
- Performs alignment and range checks, drives the RAM's enable/funct3 encoding, and returns registered read data with a one-cycle response latency.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/dmem_arbiter_rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-op encodings, RAM funct3 codes and access-size helper.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_LBU = 2'b00,
        OP_LW  = 2'b01,
        OP_SB  = 2'b10,
        OP_SW  = 2'b11
    } mem_op_e;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    function automatic logic [2:0] op_size(input mem_op_e op);
        logic [2:0] size;
        size = 3'd1;
        if (op == OP_LW || op == OP_SW) begin
            size = 3'd4;
        end
        return size;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the port that did not win last time has priority.
module rr_arb2 #(
    parameter logic RESET_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= RESET_LAST;
        end else if (advance) begin
            r_last_grant <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port byte-addressed data RAM between the LSU (port 0) and
// the loader/debug DMA (port 1), with range/alignment checks and a registered response.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 256,
    parameter logic        RESET_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_req_addr,
    input  logic [1:0]  p0_req_op,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_req_addr,
    input  logic [1:0]  p1_req_op,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_err,

    output logic [31:0] ram_address,
    output logic [31:0] ram_write_data,
    output logic        ram_w_write_enable,
    output logic        ram_b_write_enable,
    output logic        ram_read_enable,
    output logic [2:0]  ram_funct3,
    input  logic [31:0] ram_read_data
);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_sel;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    mem_op_e           w_op;
    logic [32:0]       w_addr_end;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_err;
    logic              w_is_load;

    logic              r_p0_resp_valid;
    logic [31:0]       r_p0_resp_rdata;
    logic              r_p0_resp_err;
    logic              r_p1_resp_valid;
    logic [31:0]       r_p1_resp_rdata;
    logic              r_p1_resp_err;

    // Reset masks requests so nothing is granted or driven to the RAM during reset.
    assign w_req = {p1_req_valid, p0_req_valid} & {2{~rst}};

    rr_arb2 #(
        .RESET_LAST (RESET_LAST)
    ) u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    assign w_accept     = |w_gnt;
    assign w_sel        = w_gnt[1];
    assign p0_req_ready = w_gnt[0];
    assign p1_req_ready = w_gnt[1];

    assign w_addr  = w_sel ? p1_req_addr  : p0_req_addr;
    assign w_wdata = w_sel ? p1_req_wdata : p0_req_wdata;
    assign w_op    = w_sel ? mem_op_e'(p1_req_op) : mem_op_e'(p0_req_op);

    // 33-bit end address so accesses near 2^32 cannot wrap back into range.
    assign w_addr_end     = {1'b0, w_addr} + 33'(op_size(w_op));
    assign w_out_of_range = w_addr_end > 33'(MEM_BYTES);
    assign w_misaligned   = (w_op == OP_LW || w_op == OP_SW) && (w_addr[1:0] != 2'b00);
    assign w_err          = w_misaligned || w_out_of_range;
    assign w_is_load      = (w_op == OP_LW) || (w_op == OP_LBU);

    always_comb begin
        ram_address        = 32'd0;
        ram_write_data     = 32'd0;
        ram_funct3         = F3_SB;
        ram_w_write_enable = 1'b0;
        ram_b_write_enable = 1'b0;
        ram_read_enable    = 1'b0;
        if (w_accept) begin
            ram_address    = w_addr;
            ram_write_data = w_wdata;
            case (w_op)
                OP_LBU:  ram_funct3 = F3_LBU;
                OP_LW:   ram_funct3 = F3_LW;
                OP_SB:   ram_funct3 = F3_SB;
                OP_SW:   ram_funct3 = F3_SW;
                default: ram_funct3 = F3_SB;
            endcase
            if (!w_err) begin
                ram_read_enable    = w_is_load;
                ram_w_write_enable = (w_op == OP_SW);
                ram_b_write_enable = (w_op == OP_SB);
            end
        end
    end

    // One-cycle response pulse to whichever port was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0_resp_valid <= 1'b0;
            r_p0_resp_rdata <= 32'd0;
            r_p0_resp_err   <= 1'b0;
            r_p1_resp_valid <= 1'b0;
            r_p1_resp_rdata <= 32'd0;
            r_p1_resp_err   <= 1'b0;
        end else begin
            r_p0_resp_valid <= w_gnt[0];
            r_p0_resp_err   <= w_gnt[0] & w_err;
            r_p0_resp_rdata <= (w_gnt[0] && w_is_load && !w_err) ? ram_read_data : 32'd0;
            r_p1_resp_valid <= w_gnt[1];
            r_p1_resp_err   <= w_gnt[1] & w_err;
            r_p1_resp_rdata <= (w_gnt[1] && w_is_load && !w_err) ? ram_read_data : 32'd0;
        end
    end

    assign p0_resp_valid = r_p0_resp_valid;
    assign p0_resp_rdata = r_p0_resp_rdata;
    assign p0_resp_err   = r_p0_resp_err;
    assign p1_resp_valid = r_p1_resp_valid;
    assign p1_resp_rdata = r_p1_resp_rdata;
    assign p1_resp_err   = r_p1_resp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-array RAM model behind it.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req_valid, p1_req_valid;
    logic        p0_req_ready, p1_req_ready;
    logic [31:0] p0_req_addr, p1_req_addr;
    logic [1:0]  p0_req_op, p1_req_op;
    logic [31:0] p0_req_wdata, p1_req_wdata;
    logic        p0_resp_valid, p1_resp_valid;
    logic [31:0] p0_resp_rdata, p1_resp_rdata;
    logic        p0_resp_err, p1_resp_err;
    logic [31:0] ram_address;
    logic [31:0] ram_write_data;
    logic        ram_w_write_enable;
    logic        ram_b_write_enable;
    logic        ram_read_enable;
    logic [2:0]  ram_funct3;
    logic [31:0] ram_read_data;

    int n_checks;
    int n_pass;

    logic [7:0] mem [256];

    dmem_arbiter #(
        .MEM_BYTES  (256),
        .RESET_LAST (1'b1)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .p0_req_valid       (p0_req_valid),
        .p0_req_ready       (p0_req_ready),
        .p0_req_addr        (p0_req_addr),
        .p0_req_op          (p0_req_op),
        .p0_req_wdata       (p0_req_wdata),
        .p0_resp_valid      (p0_resp_valid),
        .p0_resp_rdata      (p0_resp_rdata),
        .p0_resp_err        (p0_resp_err),
        .p1_req_valid       (p1_req_valid),
        .p1_req_ready       (p1_req_ready),
        .p1_req_addr        (p1_req_addr),
        .p1_req_op          (p1_req_op),
        .p1_req_wdata       (p1_req_wdata),
        .p1_resp_valid      (p1_resp_valid),
        .p1_resp_rdata      (p1_resp_rdata),
        .p1_resp_err        (p1_resp_err),
        .ram_address        (ram_address),
        .ram_write_data     (ram_write_data),
        .ram_w_write_enable (ram_w_write_enable),
        .ram_b_write_enable (ram_b_write_enable),
        .ram_read_enable    (ram_read_enable),
        .ram_funct3         (ram_funct3),
        .ram_read_data      (ram_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: little-endian, stores commit on posedge, reads are combinational.
    always @(posedge clk) begin
        if (ram_w_write_enable) begin
            mem[ram_address[7:0]]         <= ram_write_data[7:0];
            mem[ram_address[7:0] + 8'd1]  <= ram_write_data[15:8];
            mem[ram_address[7:0] + 8'd2]  <= ram_write_data[23:16];
            mem[ram_address[7:0] + 8'd3]  <= ram_write_data[31:24];
        end
        if (ram_b_write_enable) begin
            mem[ram_address[7:0]] <= ram_write_data[7:0];
        end
    end

    always_comb begin
        ram_read_data = 32'd0;
        if (ram_read_enable && ram_funct3 == 3'b010) begin
            ram_read_data = {mem[ram_address[7:0] + 8'd3], mem[ram_address[7:0] + 8'd2],
                             mem[ram_address[7:0] + 8'd1], mem[ram_address[7:0]]};
        end else if (ram_read_enable && ram_funct3 == 3'b100) begin
            ram_read_data = {24'd0, mem[ram_address[7:0]]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single-port transaction starting on the next cycle; checks enables and the response.
    task automatic xact(input logic port, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag,
                        input logic [2:0] exp_en, input logic [31:0] exp_rdata,
                        input logic exp_err);
        logic rdy;
        int   n;
        @(posedge clk);
        #1;
        if (port) begin
            p1_req_valid = 1'b1; p1_req_op = op; p1_req_addr = addr; p1_req_wdata = wdata;
        end else begin
            p0_req_valid = 1'b1; p0_req_op = op; p0_req_addr = addr; p0_req_wdata = wdata;
        end
        n = 0;
        @(negedge clk);
        rdy = port ? p1_req_ready : p0_req_ready;
        while (!rdy && n < 4) begin
            @(negedge clk);
            rdy = port ? p1_req_ready : p0_req_ready;
            n++;
        end
        check({tag, " ready"}, 32'(rdy), 32'd1);
        check({tag, " ram_en"}, 32'({ram_w_write_enable, ram_b_write_enable, ram_read_enable}),
              32'(exp_en));
        @(posedge clk);
        #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        @(negedge clk);
        if (port) begin
            check({tag, " resp_valid"}, 32'({p1_resp_valid, p0_resp_valid}), 32'b10);
            check({tag, " rdata"}, p1_resp_rdata, exp_rdata);
            check({tag, " err"}, 32'(p1_resp_err), 32'(exp_err));
        end else begin
            check({tag, " resp_valid"}, 32'({p1_resp_valid, p0_resp_valid}), 32'b01);
            check({tag, " rdata"}, p0_resp_rdata, exp_rdata);
            check({tag, " err"}, 32'(p0_resp_err), 32'(exp_err));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        p0_req_valid = 1'b0; p0_req_addr = 32'd0; p0_req_op = 2'b00; p0_req_wdata = 32'd0;
        p1_req_valid = 1'b0; p1_req_addr = 32'd0; p1_req_op = 2'b00; p1_req_wdata = 32'd0;

        // Reset state, including ready held low despite a pending request.
        #8;
        p0_req_valid = 1'b1;
        #1;
        check("rst ready", 32'({p1_req_ready, p0_req_ready}), 32'd0);
        check("rst ram_en", 32'({ram_w_write_enable, ram_b_write_enable, ram_read_enable}), 32'd0);
        check("rst resp", 32'({p1_resp_valid, p0_resp_valid, p1_resp_err, p0_resp_err}), 32'd0);
        check("rst rdata", p0_resp_rdata | p1_resp_rdata, 32'd0);
        p0_req_valid = 1'b0;
        #3;
        rst = 1'b0;

        // Store then load on back-to-back cycles from port 0.
        @(posedge clk);
        #1;
        p0_req_valid = 1'b1; p0_req_op = 2'b11; p0_req_addr = 32'h10; p0_req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("sw ready", 32'(p0_req_ready), 32'd1);
        check("sw ram", 32'({ram_w_write_enable, ram_b_write_enable, ram_read_enable, ram_funct3}),
              32'b100_010);
        check("sw addr", ram_address, 32'h10);
        @(posedge clk);
        #1;
        p0_req_op = 2'b01;
        @(negedge clk);
        check("lw ready", 32'(p0_req_ready), 32'd1);
        check("lw ram", 32'({ram_w_write_enable, ram_b_write_enable, ram_read_enable, ram_funct3}),
              32'b001_010);
        check("sw resp", 32'({p1_resp_valid, p0_resp_valid, p0_resp_err}), 32'b010);
        check("sw rdata", p0_resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        p0_req_valid = 1'b0;
        @(negedge clk);
        check("lw resp", 32'({p1_resp_valid, p0_resp_valid, p0_resp_err}), 32'b010);
        check("lw rdata", p0_resp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("idle no pulse", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);

        // Byte store/load from port 1.
        xact(1'b1, 2'b10, 32'h13, 32'h0000005A, "p1 sb13", 3'b010, 32'd0, 1'b0);
        xact(1'b1, 2'b00, 32'h13, 32'd0, "p1 lbu13", 3'b001, 32'h5A, 1'b0);
        xact(1'b1, 2'b01, 32'h10, 32'd0, "p1 lw10", 3'b001, 32'h5AADBEEF, 1'b0);

        // Misaligned and out-of-range accesses: accepted, err, no RAM activity.
        xact(1'b0, 2'b01, 32'h11, 32'd0, "lw11 mis", 3'b000, 32'd0, 1'b1);
        xact(1'b0, 2'b01, 32'hFE, 32'd0, "lwFE oor", 3'b000, 32'd0, 1'b1);
        xact(1'b0, 2'b11, 32'h11, 32'h12345678, "sw11 mis", 3'b000, 32'd0, 1'b1);
        xact(1'b0, 2'b11, 32'h100, 32'h12345678, "sw100 oor", 3'b000, 32'd0, 1'b1);
        xact(1'b0, 2'b01, 32'hFFFFFFFC, 32'd0, "lw wrap", 3'b000, 32'd0, 1'b1);
        xact(1'b0, 2'b01, 32'h10, 32'd0, "lw10 kept", 3'b001, 32'h5AADBEEF, 1'b0);
        xact(1'b0, 2'b01, 32'h0, 32'd0, "lw0 kept", 3'b001, 32'd0, 1'b0);

        // Upper boundary of the 256-byte RAM.
        xact(1'b1, 2'b10, 32'hFF, 32'h000000A5, "sbFF", 3'b010, 32'd0, 1'b0);
        xact(1'b1, 2'b00, 32'hFF, 32'd0, "lbuFF", 3'b001, 32'hA5, 1'b0);
        xact(1'b1, 2'b11, 32'hFC, 32'h11223344, "swFC", 3'b100, 32'd0, 1'b0);
        xact(1'b1, 2'b11, 32'hFD, 32'h99999999, "swFD", 3'b000, 32'd0, 1'b1);
        xact(1'b1, 2'b01, 32'hFC, 32'd0, "lwFC", 3'b001, 32'h11223344, 1'b0);

        // Reset pulsed mid accept-cycle drops the response and the store.
        @(posedge clk);
        #1;
        p0_req_valid = 1'b1; p0_req_op = 2'b11; p0_req_addr = 32'h20; p0_req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("mid ready", 32'(p0_req_ready), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid rst ready", 32'(p0_req_ready), 32'd0);
        check("mid rst en", 32'({ram_w_write_enable, ram_b_write_enable, ram_read_enable}), 32'd0);
        p0_req_valid = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid no pulse", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
        xact(1'b0, 2'b01, 32'h20, 32'd0, "lw20 dropped", 3'b001, 32'd0, 1'b0);

        // Two ports contend for 4 cycles: 0,1,0,1 with one response per cycle.
        // Note: the lw20 above advanced last_grant to 0, so re-reset first.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        p0_req_valid = 1'b1; p0_req_op = 2'b01; p0_req_addr = 32'h10;
        p1_req_valid = 1'b1; p1_req_op = 2'b01; p1_req_addr = 32'hFC;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("cont gnt%0d", i), 32'({p1_req_ready, p0_req_ready}),
                  (i % 2 == 0) ? 32'b01 : 32'b10);
            if (i > 0) begin
                check($sformatf("cont resp%0d", i), 32'({p1_resp_valid, p0_resp_valid}),
                      (i % 2 == 1) ? 32'b01 : 32'b10);
                check($sformatf("cont rdata%0d", i),
                      (i % 2 == 1) ? p0_resp_rdata : p1_resp_rdata,
                      (i % 2 == 1) ? 32'h5AADBEEF : 32'h11223344);
            end
            @(posedge clk);
            #1;
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        @(negedge clk);
        check("cont resp4", 32'({p1_resp_valid, p0_resp_valid}), 32'b10);
        check("cont rdata4", p1_resp_rdata, 32'h11223344);
        @(negedge clk);
        check("cont idle", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
